spi_ram_ctrl: RTL and testbench
===============================

# spi_ram_ctrl

Command-decoding single-port RAM that sits directly downstream of the SPI slave. It consumes the slave's 10-bit receive word (`rx_data`/`rx_valid`), splits it into a 2-bit command and an 8-bit payload, and performs address loads, writes and reads against an internal synchronous RAM. Read results return to the slave's `tx_data`/`tx_valid` inputs for shifting out on MISO.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; must equal 2**`ADDR_SIZE`.
- `ADDR_SIZE`, 8: address width; legal range 1..8.
- `AUTO_INC`, 0: when 1, the write address advances after each accepted write and the read address after each accepted read.
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `din`  in  10: command word from the SPI slave `rx_data`; [9:8] = command, [7:0] = payload.
- `rx_valid`  in  1: `din` valid; each high cycle is exactly one command.
- `dout`  out  8: read data to the SPI slave `tx_data`.
- `tx_valid`  out  1: one-cycle pulse, `dout` valid.
- `cmd_err`  out  1: one-cycle pulse, command rejected.

## Operation
- Commands are decoded only in cycles where `rx_valid`=1. `din` is ignored otherwise.
- 00 WR_ADDR: `wr_addr` <= payload[ADDR_SIZE-1:0]; set `wr_armed`.
- 01 WR_DATA: if `wr_armed`, mem[`wr_addr`] <= payload. If `AUTO_INC`, `wr_addr` <= `wr_addr`+1, wrapping MEM_DEPTH-1 -> 0. If not armed, memory and `wr_addr` are unchanged and `cmd_err` pulses.
- 10 RD_ADDR: `rd_addr` <= payload[ADDR_SIZE-1:0]; set `rd_armed`.
- 11 RD_DATA: payload is don't-care. If `rd_armed`, read mem[`rd_addr`]; `dout`/`tx_valid` are presented one cycle later. If `AUTO_INC`, `rd_addr` increments with wrap. If not armed, `cmd_err` pulses, `tx_valid` stays 0 and `dout` holds.
- Payload bits above `ADDR_SIZE` are discarded for address commands.
- Armed flags stay set until reset. Repeated address commands only overwrite the address.
- Write and read address registers are independent. A write to the address currently in `rd_addr` is visible to any later RD_DATA.
- Memory contents are not reset. Reset clears `wr_addr`, `rd_addr`, `wr_armed`, `rd_armed`, `dout`, `tx_valid` and `cmd_err`.

## Timing
- Reset values: `dout`=0, `tx_valid`=0, `cmd_err`=0. Outputs clear immediately on `rst` assertion, with no clock needed.
- Reset asserted mid-operation aborts a pending read: no `tx_valid` follows.
- WR_ADDR, RD_ADDR and WR_DATA take effect at the edge that samples `rx_valid`=1 (cycle N).
- A WR_DATA in cycle N followed by RD_DATA of the same address in N+1 returns the new data.
- RD_DATA latency: command sampled at edge N; `dout` updated and `tx_valid`=1 for the cycle after edge N+1; `tx_valid`=0 after edge N+2 unless another RD_DATA was sampled at N+1.
- Back-to-back RD_DATA on consecutive cycles gives consecutive `tx_valid` pulses, one data word per cycle.
- `cmd_err` rises at the edge after the rejected command and lasts one cycle.
- Single-port RAM: at most one access per cycle. This is guaranteed because at most one command arrives per cycle.
- `dout` holds its last value between reads.

## Structure
- Shared package `spi_ram_pkg`:
  - command encodings `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11;
  - field positions `CMD_MSB`=9, `CMD_LSB`=8, `PAYLOAD_W`=8.
  - The SPI slave imports the same package.
- Sub-module `spi_ram_array`: MEM_DEPTH x 8 single-port RAM with synchronous write and registered synchronous read (`clk`, `we`, `re`, `addr`, `wdata`, `rdata`); no reset on the array.
- `spi_ram_ctrl` holds the decoder, the address and armed registers, the read-valid pipeline flop, and `cmd_err`.

## Test plan
- Reset, then WR_DATA 0x1A5 with no prior WR_ADDR -> `cmd_err` pulses 1 cycle; a later WR_ADDR 0x005 then RD_ADDR 0x205, RD_DATA shows the location was not written.
- WR_ADDR 0x03C, WR_DATA 0x1A5, RD_ADDR 0x23C, RD_DATA 0x300 -> `dout`=0xA5 with a single `tx_valid` pulse one cycle after the RD_DATA sample edge.
- `AUTO_INC`=1: WR_ADDR 0x0FF, WR_DATA 0x111, WR_DATA 0x122 -> mem[0xFF]=0x11, mem[0x00]=0x22 (wrap); RD_ADDR 0x2FF plus two back-to-back RD_DATA -> `dout` 0x11 then 0x22 on consecutive cycles.
- WR_ADDR 0x010, WR_DATA 0x177, RD_ADDR 0x210, then WR_DATA 0x188 in cycle N and RD_DATA in N+1 -> `dout`=0x88.
- RD_DATA sampled, `rst` pulsed before the next edge -> `tx_valid` never rises, `dout`=0, both armed flags cleared (next RD_DATA -> `cmd_err`).
- `rx_valid`=0 with random `din` for 100 cycles -> no memory change, `tx_valid`=0, `cmd_err`=0.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI slave command word and the RAM controller.
package spi_ram_pkg;

  localparam int CMD_MSB   = 9;
  localparam int CMD_LSB   = 8;
  localparam int PAYLOAD_W = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port RAM: synchronous write, registered synchronous read.
module spi_ram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder and address/armed state in front of a single-port RAM;
// read data is returned one cycle after the array's registered read.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  logic [1:0]           cmd;
  logic [PAYLOAD_W-1:0] payload;
  logic                 is_wa, is_wd, is_ra, is_rd;
  logic                 we, re;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, addr;
  logic                 wr_armed, rd_armed, rd_pend;
  logic [7:0]           rdata;

  assign cmd     = din[CMD_MSB:CMD_LSB];
  assign payload = din[PAYLOAD_W-1:0];

  always_comb begin
    is_wa = 1'b0;
    is_wd = 1'b0;
    is_ra = 1'b0;
    is_rd = 1'b0;
    if (rx_valid) begin
      unique case (1'b1)
        (cmd == CMD_WR_ADDR): is_wa = 1'b1;
        (cmd == CMD_WR_DATA): is_wd = 1'b1;
        (cmd == CMD_RD_ADDR): is_ra = 1'b1;
        (cmd == CMD_RD_DATA): is_rd = 1'b1;
      endcase
    end
  end

  assign we   = is_wd & wr_armed;
  assign re   = is_rd & rd_armed;
  // One command per cycle, so the port is never contended.
  assign addr = we ? wr_addr : rd_addr;

  spi_ram_array #(
    .DEPTH(MEM_DEPTH),
    .AW   (ADDR_SIZE)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .re   (re),
    .addr (addr),
    .wdata(payload),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_armed <= 1'b0;
      rd_armed <= 1'b0;
      rd_pend  <= 1'b0;
      dout     <= '0;
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err  <= (is_wd & ~wr_armed) | (is_rd & ~rd_armed);
      rd_pend  <= re;
      tx_valid <= rd_pend;
      if (rd_pend) dout <= rdata;
      if (is_wa) begin
        wr_addr  <= payload[ADDR_SIZE-1:0];
        wr_armed <= 1'b1;
      end
      if (is_ra) begin
        rd_addr  <= payload[ADDR_SIZE-1:0];
        rd_armed <= 1'b1;
      end
      if (we && AUTO_INC != 0) wr_addr <= wr_addr + ADDR_SIZE'(1);
      if (re && AUTO_INC != 0) rd_addr <= rd_addr + ADDR_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomized bench for spi_ram_ctrl: two instances (AUTO_INC 0 and 1)
// checked every cycle against a command-level reference model.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] din [2];
  logic       rxv [2];
  logic [7:0] dout [2];
  logic       txv [2];
  logic       err [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din[0]), .rx_valid(rxv[0]),
    .dout(dout[0]), .tx_valid(txv[0]), .cmd_err(err[0])
  );

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din[1]), .rx_valid(rxv[1]),
    .dout(dout[1]), .tx_valid(txv[1]), .cmd_err(err[1])
  );

  // Reference model state per instance
  logic [7:0] mmem   [2][256];
  bit         mknown [2][256];
  logic [7:0] mwa [2], mra [2];
  bit         mwae [2], mrae [2];
  bit         mpend [2], mpk [2];
  logic [7:0] mpd [2];
  logic [7:0] mexp [2];
  bit         mexpk [2];
  int         inc [2] = '{0, 1};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mwa[k] = 0; mra[k] = 0;
      mwae[k] = 0; mrae[k] = 0;
      mpend[k] = 0; mpk[k] = 0;
      mexp[k] = 0; mexpk[k] = 1;
    end
  endtask

  // One clock: drive instance i, idle the other, then check both.
  task automatic step(int i, bit v, logic [9:0] d, string tag);
    bit vk, etv, eerr;
    logic [9:0] dk;
    din[i] = d; rxv[i] = v;
    din[1-i] = 10'($urandom); rxv[1-i] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      vk = (k == i) ? v : 1'b0;
      dk = d;
      etv = mpend[k];
      if (mpend[k]) begin
        mexp[k] = mpd[k];
        mexpk[k] = mpk[k];
      end
      mpend[k] = 0;
      eerr = 0;
      if (vk) begin
        case (dk[9:8])
          2'b00: begin mwa[k] = dk[7:0]; mwae[k] = 1; end
          2'b01: begin
            if (mwae[k]) begin
              mmem[k][mwa[k]] = dk[7:0];
              mknown[k][mwa[k]] = 1;
              if (inc[k] != 0) mwa[k] = mwa[k] + 8'd1;
            end else eerr = 1;
          end
          2'b10: begin mra[k] = dk[7:0]; mrae[k] = 1; end
          default: begin
            if (mrae[k]) begin
              mpend[k] = 1;
              mpd[k] = mmem[k][mra[k]];
              mpk[k] = mknown[k][mra[k]];
              if (inc[k] != 0) mra[k] = mra[k] + 8'd1;
            end else eerr = 1;
          end
        endcase
      end
      checks++;
      if (txv[k] !== etv) begin
        errors++;
        $display("FAIL %s dut%0d tx_valid: got %b want %b", tag, k, txv[k], etv);
      end
      checks++;
      if (err[k] !== eerr) begin
        errors++;
        $display("FAIL %s dut%0d cmd_err: got %b want %b", tag, k, err[k], eerr);
      end
      if (mexpk[k]) begin
        checks++;
        if (dout[k] !== mexp[k]) begin
          errors++;
          $display("FAIL %s dut%0d dout: got %h want %h", tag, k, dout[k], mexp[k]);
        end
      end
    end
    rxv[i] = 1'b0;
  endtask

  task automatic idle(int n, string tag);
    for (int j = 0; j < n; j++) step(0, 1'b0, 10'($urandom), tag);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dout[k] !== 8'h00 || txv[k] !== 1'b0 || err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: got dout=%h tv=%b err=%b want 00/0/0",
                 k, dout[k], txv[k], err[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(2, "reset_idle");
  endtask

  task automatic test_unarmed_write();
    step(0, 1, 10'h005, "unarm_pre");
    step(0, 1, 10'h133, "unarm_pre");
    test_reset();
    step(0, 1, 10'h1A5, "unarm_wr");
    idle(1, "unarm_after");
    step(0, 1, 10'h005, "unarm_wa");
    step(0, 1, 10'h205, "unarm_ra");
    step(0, 1, 10'h300, "unarm_rd");
    idle(3, "unarm_result");
  endtask

  task automatic test_write_read();
    step(0, 1, 10'h03C, "wr_rd");
    step(0, 1, 10'h1A5, "wr_rd");
    step(0, 1, 10'h23C, "wr_rd");
    step(0, 1, 10'h300, "wr_rd");
    idle(3, "wr_rd_out");
  endtask

  task automatic test_auto_inc();
    step(1, 1, 10'h0FF, "autoinc");
    step(1, 1, 10'h111, "autoinc");
    step(1, 1, 10'h122, "autoinc");
    step(1, 1, 10'h2FF, "autoinc");
    step(1, 1, 10'h300, "autoinc_rd0");
    step(1, 1, 10'h300, "autoinc_rd1");
    idle(3, "autoinc_out");
  endtask

  task automatic test_back_to_back();
    step(1, 1, 10'h040, "b2b");
    for (int j = 0; j < 6; j++) step(1, 1, {2'b01, 8'($urandom)}, "b2b_wr");
    step(1, 1, 10'h240, "b2b");
    for (int j = 0; j < 6; j++) step(1, 1, 10'h3AA, "b2b_rd");
    idle(3, "b2b_out");
  endtask

  task automatic test_write_then_read();
    step(0, 1, 10'h010, "raw");
    step(0, 1, 10'h177, "raw");
    step(0, 1, 10'h210, "raw");
    step(0, 1, 10'h188, "raw_wr");
    step(0, 1, 10'h300, "raw_rd");
    idle(3, "raw_out");
  endtask

  task automatic test_reset_pending_read();
    step(0, 1, 10'h300, "rstrd_cmd");
    #2 rst = 1'b1;
    #1;
    checks++;
    if (txv[0] !== 1'b0 || dout[0] !== 8'h00) begin
      errors++;
      $display("FAIL rstrd_async: got tv=%b dout=%h want 0/00", txv[0], dout[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (txv[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstrd_edge tx_valid: got %b want 0", txv[0]);
    end
    rst = 1'b0;
    model_reset();
    idle(2, "rstrd_idle");
    step(0, 1, 10'h300, "rstrd_rd_unarmed");
    step(0, 1, 10'h155, "rstrd_wr_unarmed");
    idle(2, "rstrd_tail");
  endtask

  task automatic test_idle_ignore();
    for (int j = 0; j < 100; j++)
      step(j % 2, 1'b0, 10'($urandom), "idle_ignore");
    step(0, 1, 10'h23C, "idle_chk");
    step(0, 1, 10'h300, "idle_chk");
    step(0, 1, 10'h210, "idle_chk");
    step(0, 1, 10'h300, "idle_chk");
    step(1, 1, 10'h2FF, "idle_chk");
    step(1, 1, 10'h300, "idle_chk");
    step(1, 1, 10'h300, "idle_chk");
    idle(3, "idle_chk_out");
  endtask

  task automatic test_random();
    logic [9:0] d;
    for (int j = 0; j < 600; j++) begin
      d = 10'($urandom);
      // Keep addresses in a small window so reads hit written words
      if (d[9:8] == 2'b00 || d[9:8] == 2'b10) d[7:4] = 4'hC;
      step(int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), d, "random");
    end
    idle(3, "random_out");
  endtask

  initial begin
    din[0] = '0; din[1] = '0;
    rxv[0] = 1'b0; rxv[1] = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) begin
        mmem[k][a] = 8'h00;
        mknown[k][a] = 0;
      end
    model_reset();
    test_reset();
    test_unarmed_write();
    test_write_read();
    test_auto_inc();
    test_back_to_back();
    test_write_then_read();
    test_idle_ignore();
    test_reset_pending_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
